// File: rtl/serial_pkg.sv
// Shared constants and types for the serial transmit arbiter slice.
package serial_pkg;

    localparam int unsigned NUM_REQ_DEFAULT        = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 65535;
    localparam int unsigned IDLE_CNT_WIDTH         = 16;

    // Transmitter bit period: 6 MHz system clock at 9600 baud.
    localparam int unsigned CLOCK_HZ          = 6_000_000;
    localparam int unsigned BAUD_RATE         = 9600;
    localparam int unsigned BIT_PERIOD_CYCLES = CLOCK_HZ / BAUD_RATE;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } state_t;

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester byte streams, transmitter handshake and lock status between arbiter and its users.
interface serial_tx_arbiter_if
    import serial_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic [7:0]              tx_data;
    logic                    tx_data_available;
    logic                    tx_ready;
    logic                    grant_active;
    logic [ID_W-1:0]         grant_id;
    logic                    timeout_pulse;

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_data_available, grant_active, grant_id, timeout_pulse
    );

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_data_available, grant_active, grant_id, timeout_pulse
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit after last_grant, wrapping modulo NUM_REQ.
module rr_pick
    import serial_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        found   = 1'b0;
        idx     = '0;
        cand    = 0;
        cand_id = '0;
        // Walk the order backwards so the nearest candidate is written last and wins.
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            cand    = (int'(last_grant) + i) % int'(NUM_REQ);
            cand_id = cand[ID_W-1:0];
            if (req[cand_id]) begin
                found = 1'b1;
                idx   = cand_id;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding several byte streams into one serial transmitter.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic                clock,
    input logic                reset,
    serial_tx_arbiter_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_LIMIT = IDLE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                    state_q;
    logic [ID_W-1:0]           grant_id_q;
    logic [ID_W-1:0]           last_grant_q;
    logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q;
    logic                      timeout_pulse_q;

    logic                      pick_found;
    logic [ID_W-1:0]           pick_idx;
    logic                      sel_valid;
    logic                      sel_last;
    logic                      xfer;
    logic [NUM_REQ-1:0]        ready;
    logic [7:0]                tx_data;
    logic                      tx_avail;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    assign sel_valid = bus.req_valid[grant_id_q];
    assign sel_last  = bus.req_last[grant_id_q];
    assign xfer      = (state_q == StLocked) && sel_valid && bus.tx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            grant_id_q      <= '0;
            last_grant_q    <= ID_W'(NUM_REQ - 1);
            idle_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            timeout_pulse_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q    <= StLocked;
                        grant_id_q <= pick_idx;
                        idle_cnt_q <= '0;
                    end
                end
                StLocked: begin
                    // A transfer always takes priority; timeout only counts empty cycles.
                    if (xfer) begin
                        idle_cnt_q <= '0;
                        if (sel_last) begin
                            state_q      <= StIdle;
                            last_grant_q <= grant_id_q;
                        end
                    end else if (!sel_valid) begin
                        if (idle_cnt_q == IDLE_LIMIT) begin
                            state_q         <= StIdle;
                            last_grant_q    <= grant_id_q;
                            timeout_pulse_q <= 1'b1;
                            idle_cnt_q      <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IDLE_CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ready    = '0;
        tx_data  = 8'h00;
        tx_avail = 1'b0;
        if (state_q == StLocked) begin
            tx_data           = bus.req_data[grant_id_q];
            tx_avail          = sel_valid;
            ready[grant_id_q] = bus.tx_ready;
        end
    end

    assign bus.req_ready         = ready;
    assign bus.tx_data           = tx_data;
    assign bus.tx_data_available = tx_avail;
    assign bus.grant_active      = (state_q == StLocked);
    assign bus.grant_id          = grant_id_q;
    assign bus.timeout_pulse     = timeout_pulse_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench: FIFO-backed requesters and a busy-after-capture transmitter model around the arbiter.
module tb_serial_tx_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam int          TX_BUSY = 3;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic tx_hold = 1'b0;

    int errors     = 0;
    int checks     = 0;
    int ready_viol = 0;

    logic [8:0]  fifo   [NREQ][16];
    int unsigned wr_ptr [NREQ];
    int unsigned rd_ptr [NREQ] = '{0, 0};
    int          busy = 0;
    logic [8:0]  cap [$];

    serial_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    serial_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always_comb begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (wr_ptr[i] != rd_ptr[i]);
            bus.req_last[i]  = fifo[i][rd_ptr[i][3:0]][8];
            bus.req_data[i]  = fifo[i][rd_ptr[i][3:0]][7:0];
        end
    end

    assign bus.tx_ready = (busy == 0) && !tx_hold;

    always @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
        if (bus.tx_data_available && bus.tx_ready) begin
            cap.push_back({bus.grant_id, bus.tx_data});
            busy <= TX_BUSY;
        end else if (busy != 0) begin
            busy <= busy - 1;
        end
    end

    // Any ready must be the holder's bit only, and only while the transmitter is ready.
    always @(negedge clock) begin
        if (bus.req_ready != '0) begin
            if (!bus.tx_ready || !bus.grant_active ||
                (bus.req_ready != (2'b01 << bus.grant_id))) ready_viol++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic push(input int id, input logic last, input logic [7:0] data);
        fifo[id][wr_ptr[id][3:0]] = {last, data};
        wr_ptr[id] = wr_ptr[id] + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NREQ; i++) wr_ptr[i] = rd_ptr[i];
        reset = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int bound);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < bound) begin
            at_neg();
            if (wr_ptr[0] == rd_ptr[0] && wr_ptr[1] == rd_ptr[1] && !bus.grant_active) done = 1'b1;
            n++;
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: not idle after %0d cycles, want idle", name, bound);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        at_neg();
        checks += 6;
        if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active: got %b want 0", bus.grant_active); end
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        if (bus.tx_data_available !== 1'b0) begin errors++; $display("FAIL reset_tx_avail: got %b want 0", bus.tx_data_available); end
        if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_pulse); end
        if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_three_bytes();
        int         base;
        logic [8:0] got;
        logic [8:0] exp;
        base = cap.size();
        push(0, 1'b0, 8'h41);
        push(0, 1'b0, 8'h42);
        push(0, 1'b1, 8'h43);
        at_neg();
        checks++;
        if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL three_latency: got %b want 0", bus.grant_active); end
        tick();
        at_neg();
        checks += 3;
        if (bus.grant_active !== 1'b1) begin errors++; $display("FAIL three_grant: got %b want 1", bus.grant_active); end
        if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL three_grant_id: got %0d want 0", bus.grant_id); end
        if (bus.tx_data !== 8'h41 || bus.tx_data_available !== 1'b1) begin
            errors++;
            $display("FAIL three_tx_first: got %h/%b want 41/1", bus.tx_data, bus.tx_data_available);
        end
        tick();
        wait_drained("three", 40);
        checks++;
        if (cap.size() - base != 3) begin errors++; $display("FAIL three_count: got %0d want 3", cap.size() - base); end
        for (int k = 0; k < 3; k++) begin
            got = (base + k < cap.size()) ? cap[base + k] : 9'bx;
            exp = 9'h041 + 9'(k);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL three_byte%0d: got %h want %h", k, got, exp); end
        end
    endtask

    task automatic test_round_robin();
        int         base;
        logic [8:0] got;
        logic [8:0] exp [8];
        exp = '{9'h0A0, 9'h0A1, 9'h1B0, 9'h1B1, 9'h0A2, 9'h0A3, 9'h1B2, 9'h1B3};
        do_reset();
        repeat (4) tick();
        base = cap.size();
        push(0, 1'b0, 8'hA0); push(0, 1'b1, 8'hA1); push(0, 1'b0, 8'hA2); push(0, 1'b1, 8'hA3);
        push(1, 1'b0, 8'hB0); push(1, 1'b1, 8'hB1); push(1, 1'b0, 8'hB2); push(1, 1'b1, 8'hB3);
        wait_drained("rr", 120);
        for (int k = 0; k < 8; k++) begin
            got = (base + k < cap.size()) ? cap[base + k] : 9'bx;
            checks++;
            if (got !== exp[k]) begin errors++; $display("FAIL rr_byte%0d: got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_timeout();
        int         base;
        int         early;
        logic [8:0] got;
        repeat (4) tick();
        base = cap.size();
        push(1, 1'b0, 8'h10);
        tick();
        at_neg();
        checks++;
        if (bus.grant_id !== 1'b1 || bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL to_grant: got id %0d ready %b want 1/10", bus.grant_id, bus.req_ready);
        end
        tick();
        early = 0;
        repeat (8) begin
            at_neg();
            if (bus.timeout_pulse !== 1'b0 || bus.grant_active !== 1'b1) early++;
            tick();
        end
        at_neg();
        got = (base < cap.size()) ? cap[base] : 9'bx;
        checks += 4;
        if (early != 0) begin errors++; $display("FAIL to_early: got %0d bad cycles want 0", early); end
        if (got !== 9'h110) begin errors++; $display("FAIL to_byte: got %h want 110", got); end
        if (bus.timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", bus.timeout_pulse); end
        if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL to_release: got %b want 0", bus.grant_active); end
        tick();
        at_neg();
        checks++;
        if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", bus.timeout_pulse); end
        tick();
        push(0, 1'b1, 8'h20);
        push(1, 1'b1, 8'h21);
        tick();
        at_neg();
        checks++;
        if (bus.grant_active !== 1'b1 || bus.grant_id !== 1'b0) begin
            errors++;
            $display("FAIL to_next_winner: got %b/%0d want 1/0", bus.grant_active, bus.grant_id);
        end
        tick();
        wait_drained("to", 60);
    endtask

    task automatic test_hold_no_timeout();
        int         base;
        int         bad;
        logic [8:0] got;
        repeat (4) tick();
        tx_hold = 1'b1;
        base    = cap.size();
        push(0, 1'b1, 8'h55);
        tick();
        bad = 0;
        repeat (20) begin
            at_neg();
            if (bus.timeout_pulse !== 1'b0 || bus.grant_active !== 1'b1 || cap.size() != base) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_stall: got %0d bad cycles want 0", bad); end
        tx_hold = 1'b0;
        at_neg();
        checks++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL hold_ready: got %b want 01", bus.req_ready); end
        tick();
        at_neg();
        got = (base < cap.size()) ? cap[base] : 9'bx;
        checks += 2;
        if (got !== 9'h055) begin errors++; $display("FAIL hold_byte: got %h want 055", got); end
        if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", bus.grant_active); end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        int base;
        bit got;
        repeat (4) tick();
        base = cap.size();
        push(1, 1'b0, 8'hC0); push(1, 1'b0, 8'hC1); push(1, 1'b0, 8'hC2); push(1, 1'b1, 8'hC3);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            at_neg();
            if (cap.size() > base) got = 1'b1;
            else tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rst_first_byte: got none want 1 byte"); end
        tick();
        reset = 1'b1;
        tick();
        at_neg();
        checks += 4;
        if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b want 0", bus.grant_active); end
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", bus.req_ready); end
        if (bus.tx_data_available !== 1'b0) begin errors++; $display("FAIL rst_avail: got %b want 0", bus.tx_data_available); end
        if (cap.size() - base != 1) begin errors++; $display("FAIL rst_bytes: got %0d want 1", cap.size() - base); end
        tick();
        for (int i = 0; i < NREQ; i++) wr_ptr[i] = rd_ptr[i];
        reset = 1'b0;
        push(0, 1'b1, 8'h30);
        push(1, 1'b1, 8'h31);
        tick();
        at_neg();
        checks++;
        if (bus.grant_active !== 1'b1 || bus.grant_id !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_winner: got %b/%0d want 1/0", bus.grant_active, bus.grant_id);
        end
        tick();
        wait_drained("rst", 60);
    endtask

    task automatic test_single_byte();
        int         base;
        logic [8:0] got;
        repeat (4) tick();
        base = cap.size();
        push(1, 1'b1, 8'hFF);
        tick();
        push(0, 1'b1, 8'h66);
        at_neg();
        checks += 2;
        if (bus.grant_id !== 1'b1 || bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL single_grant: got id %0d ready %b want 1/10", bus.grant_id, bus.req_ready);
        end
        if (bus.tx_data !== 8'hFF) begin errors++; $display("FAIL single_tx_data: got %h want FF", bus.tx_data); end
        tick();
        at_neg();
        got = (base < cap.size()) ? cap[base] : 9'bx;
        checks += 4;
        if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.grant_active); end
        if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL single_idle_data: got %h want 00", bus.tx_data); end
        if (got !== 9'h1FF) begin errors++; $display("FAIL single_byte: got %h want 1FF", got); end
        if (cap.size() - base != 1) begin errors++; $display("FAIL single_count: got %0d want 1", cap.size() - base); end
        tick();
        at_neg();
        checks++;
        if (bus.grant_active !== 1'b1 || bus.grant_id !== 1'b0) begin
            errors++;
            $display("FAIL single_next: got %b/%0d want 1/0", bus.grant_active, bus.grant_id);
        end
        tick();
        wait_drained("single", 40);
        checks++;
        if (ready_viol != 0) begin errors++; $display("FAIL ready_rule: got %0d bad cycles want 0", ready_viol); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            wr_ptr[i] = 0;
            for (int j = 0; j < 16; j++) fifo[i][j] = '0;
        end
        test_reset();
        test_three_bytes();
        test_round_robin();
        test_timeout();
        test_hold_no_timeout();
        test_reset_mid_packet();
        test_single_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
